// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and helpers for the synchronous instruction memory
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] NOP   = 32'h0;
  localparam int          MAX_W = 256;

  // Reverse the order of the low nbytes bytes of word; upper bytes come back zero
  function automatic logic [MAX_W-1:0] byte_swap(input logic [MAX_W-1:0] word, input int nbytes);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W / 8; i++) begin
      if (i < nbytes) r[8*(nbytes-1-i) +: 8] = word[8*i +: 8];
    end
    return r;
  endfunction

  // Word index of a byte address, wrapped to the memory depth (depth is a power of two)
  function automatic logic [29:0] word_index(input logic [31:0] pc, input int depth);
    return pc[31:2] & 30'(depth - 1);
  endfunction

endpackage

// File: rtl/imem_sync_if.sv
// rtl/imem_sync_if.sv - loader and fetch handshake bundle for imem_sync
interface imem_sync_if #(
  parameter int WORD_W = 32
);
  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              fetch_req;
  logic [31:0]       pc;
  logic              fetch_ready;
  logic [WORD_W-1:0] inst;
  logic              inst_valid;
  logic              fault_misalign;
  logic              fault_range;

  modport master (
    output ld_valid, ld_data, ld_last, fetch_req, pc,
    input  ld_ready, ld_done, fetch_ready, inst, inst_valid, fault_misalign, fault_range
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, fetch_req, pc,
    output ld_ready, ld_done, fetch_ready, inst, inst_valid, fault_misalign, fault_range
  );
endinterface

// File: rtl/imem_rd_pipe.sv
// rtl/imem_rd_pipe.sv - fixed-latency response chain carrying valid, faults and data
module imem_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic         i_misalign,
  input  logic         i_range,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic         o_misalign,
  output logic         o_range,
  output logic [W-1:0] o_data
);

  typedef struct packed {
    logic         valid;
    logic         misalign;
    logic         rng;
    logic [W-1:0] data;
  } stage_t;

  stage_t r_stage [LAT];

  // Stage 0 captures the memory read; later stages are pure delay so responses stay in order
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= '{valid: i_valid, misalign: i_misalign, rng: i_range, data: i_data};
      for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_valid    = r_stage[LAT-1].valid;
  assign o_misalign = r_stage[LAT-1].misalign;
  assign o_range    = r_stage[LAT-1].rng;
  assign o_data     = r_stage[LAT-1].data;

endmodule

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - clocked instruction memory with loader port and pipelined fetch port
module imem_sync
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int WORD_W      = 32,
  parameter int READ_LAT    = 1,
  parameter int BIG_ENDIAN  = 1
) (
  input logic        clk,
  input logic        reset,
  imem_sync_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rst_hold;
  logic [AW-1:0]     r_ld_ptr;
  logic [AW:0]       r_ld_count;
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  logic              w_ld_ready;
  logic              w_fetch_ready;
  logic              w_ld_done;
  logic              w_ld_acc;
  logic              w_fetch_acc;
  logic              w_misalign;
  logic              w_range;
  logic              w_unloaded;
  logic [AW-1:0]     w_idx;
  logic [WORD_W-1:0] w_rd_word;
  logic [WORD_W-1:0] w_rd_order;
  logic [WORD_W-1:0] w_rd_data;
  logic              w_pipe_misalign;
  logic              w_pipe_range;

  // State register; r_rst_hold keeps every output low for the cycle after reset is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LOAD;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_hold <= 1'b0;
    end
  end

  // Next state and port handshakes; a full memory ends the load even without ld_last
  always_comb begin
    w_state_nxt   = r_state;
    w_ld_ready    = 1'b0;
    w_fetch_ready = 1'b0;
    w_ld_done     = 1'b0;
    case (r_state)
      LOAD: begin
        w_ld_ready = !r_rst_hold;
        if (bus.ld_valid && w_ld_ready &&
            (bus.ld_last || r_ld_ptr == AW'(DEPTH_WORDS - 1))) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_fetch_ready = 1'b1;
        w_ld_done     = 1'b1;
      end
    endcase
  end

  assign w_ld_acc    = bus.ld_valid && w_ld_ready;
  assign w_fetch_acc = bus.fetch_req && w_fetch_ready;

  // Load pointer and count of words written since reset; the count hides stale contents
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_ptr   <= '0;
      r_ld_count <= '0;
    end else if (w_ld_acc) begin
      r_ld_ptr   <= r_ld_ptr + AW'(1);
      r_ld_count <= r_ld_count + (AW+1)'(1);
    end
  end

  // Single-port array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_ld_acc && !reset) r_mem[r_ld_ptr] <= bus.ld_data;
  end

  assign w_misalign = bus.pc[1:0] != 2'b00;
  assign w_range    = !w_misalign && ({2'b00, bus.pc[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx      = AW'(word_index(bus.pc, DEPTH_WORDS));
  assign w_unloaded = {1'b0, w_idx} >= r_ld_count;
  assign w_rd_word  = r_mem[w_idx];

  if (BIG_ENDIAN != 0) begin : g_be
    assign w_rd_order = w_rd_word;
  end else begin : g_le
    assign w_rd_order = WORD_W'(byte_swap(MAX_W'(w_rd_word), WORD_W / 8));
  end

  // Faulting, unloaded or idle reads carry NOP so the pipe output is zero unless valid and clean
  always_comb begin
    w_rd_data = WORD_W'(NOP);
    if (w_fetch_acc && !w_misalign && !w_range && !w_unloaded) w_rd_data = w_rd_order;
  end

  assign w_pipe_misalign = w_fetch_acc && w_misalign;
  assign w_pipe_range    = w_fetch_acc && w_range;

  imem_rd_pipe #(
    .LAT (READ_LAT),
    .W   (WORD_W)
  ) u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (w_fetch_acc),
    .i_misalign (w_pipe_misalign),
    .i_range    (w_pipe_range),
    .i_data     (w_rd_data),
    .o_valid    (bus.inst_valid),
    .o_misalign (bus.fault_misalign),
    .o_range    (bus.fault_range),
    .o_data     (bus.inst)
  );

  assign bus.ld_ready    = w_ld_ready;
  assign bus.ld_done     = w_ld_done;
  assign bus.fetch_ready = w_fetch_ready;

endmodule
